// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - shared types and alignment helpers for the split load/store unit
// Contents: mem_dt_e access types, errno_e completion codes (including EALIGN),
//   lsu_state_e sequencer states, lsu_is_aligned() and lsu_beats() helpers.
package mem_lsu_pkg;

  typedef enum logic [2:0] {
    MEM_DT_BYTE  = 3'd0,
    MEM_DT_UBYTE = 3'd1,
    MEM_DT_HALF  = 3'd2,
    MEM_DT_UHALF = 3'd3,
    MEM_DT_WORD  = 3'd4
  } mem_dt_e;

  typedef enum logic [2:0] {
    ENONE  = 3'd0,
    EFAULT = 3'd1,
    EBUS   = 3'd2,
    EALIGN = 3'd3
  } errno_e;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_ACCESS = 2'd1,
    LSU_RESP   = 2'd2
  } lsu_state_e;

  function automatic logic lsu_is_aligned(input logic [1:0] addr_lo, input mem_dt_e dt);
    case (dt)
      MEM_DT_HALF, MEM_DT_UHALF: return (addr_lo[0] == 1'b0);
      MEM_DT_WORD:               return (addr_lo == 2'b00);
      default:                   return 1'b1;
    endcase
  endfunction

  // Returns the number of beats minus one, so it fits the 2-bit beat counter.
  function automatic logic [1:0] lsu_beats(input logic [1:0] addr_lo, input mem_dt_e dt);
    if (lsu_is_aligned(addr_lo, dt)) return 2'd0;
    if (dt == MEM_DT_WORD)           return 2'd3;
    return 2'd1;
  endfunction

endpackage

// File: rtl/mem_split_extend.sv
// rtl/mem_split_extend.sv - sign/zero extension of the assembled load bytes
// Ports: asm_i  assembled load bytes (byte lane k = byte at addr+k)
//        dt_i   access type of the load
//        data_o extended 32-bit load result
module mem_split_extend
  import mem_lsu_pkg::*;
(
  input  logic [31:0] asm_i,
  input  mem_dt_e     dt_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = asm_i;
    case (dt_i)
      MEM_DT_BYTE:  data_o = {{24{asm_i[7]}}, asm_i[7:0]};
      MEM_DT_UBYTE: data_o = {24'h0, asm_i[7:0]};
      MEM_DT_HALF:  data_o = {{16{asm_i[15]}}, asm_i[15:0]};
      MEM_DT_UHALF: data_o = {16'h0, asm_i[15:0]};
      default:      data_o = asm_i;
    endcase
  end

endmodule

// File: rtl/mem_split_lsu.sv
// rtl/mem_split_lsu.sv - load/store sequencer splitting misaligned accesses into byte beats
// Ports: clk/rst_n clock and async active-low reset
//        req_*  request handshake (valid/ready) with addr, wdata, we, dt
//        resp_* one-cycle completion pulse with extended rdata and error code
//        mem_*  single-port data memory interface (combinational read)
module mem_split_lsu
  import mem_lsu_pkg::*;
#(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_we,
  input  mem_dt_e     req_dt,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output errno_e      resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  output mem_dt_e     mem_dt,
  input  logic [31:0] mem_rd,
  input  errno_e      mem_err
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        we_q, we_d;
  mem_dt_e     dt_q, dt_d;
  logic [1:0]  last_q, last_d, beat_q, beat_d;
  logic [31:0] asm_q, asm_d, rdata_q, rdata_d;
  errno_e      err_q, err_d;
  logic [31:0] ext_data;

  // Extension sees the assembly value including the byte captured this beat,
  // so the final result is available at the edge that ends the last beat.
  mem_split_extend u_ext (
    .asm_i  (asm_d),
    .dt_i   (dt_q),
    .data_o (ext_data)
  );

  assign req_ready  = (state_q == LSU_IDLE);
  assign resp_valid = (state_q == LSU_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    dt_d     = dt_q;
    last_d   = last_q;
    beat_d   = beat_q;
    asm_d    = asm_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    mem_addr = 32'h0;
    mem_wd   = 32'h0;
    mem_we   = 1'b0;
    mem_dt   = MEM_DT_WORD;
    case (state_q)
      LSU_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          we_d    = req_we;
          dt_d    = req_dt;
          last_d  = lsu_beats(req_addr[1:0], req_dt);
          beat_d  = 2'd0;
          asm_d   = 32'h0;
          if (!SPLIT_EN && !lsu_is_aligned(req_addr[1:0], req_dt)) begin
            err_d   = EALIGN;
            rdata_d = 32'h0;
            state_d = LSU_RESP;
          end else begin
            err_d   = ENONE;
            state_d = LSU_ACCESS;
          end
        end
      end
      LSU_ACCESS: begin
        mem_we = we_q;
        // last_q == 0 only for aligned requests: one native-width access.
        if (last_q == 2'd0) begin
          mem_addr = addr_q;
          mem_dt   = dt_q;
          mem_wd   = wdata_q;
          asm_d    = mem_rd;
        end else begin
          mem_addr = addr_q + {30'h0, beat_q};
          mem_dt   = we_q ? MEM_DT_BYTE : MEM_DT_UBYTE;
          mem_wd   = wdata_q >> {beat_q, 3'b000};
          asm_d[{beat_q, 3'b000} +: 8] = mem_rd[7:0];
        end
        if (mem_err != ENONE) begin
          err_d   = mem_err;
          rdata_d = we_q ? 32'h0 : ext_data;
          state_d = LSU_RESP;
        end else if (beat_q == last_q) begin
          rdata_d = we_q ? 32'h0 : ext_data;
          state_d = LSU_RESP;
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end
      LSU_RESP: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LSU_IDLE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      we_q    <= 1'b0;
      dt_q    <= MEM_DT_WORD;
      last_q  <= 2'd0;
      beat_q  <= 2'd0;
      asm_q   <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= ENONE;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      dt_q    <= dt_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      asm_q   <= asm_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_split_lsu.sv
// tb/tb_mem_split_lsu.sv - self-checking bench for mem_split_lsu against a byte-level memory model
module tb_mem_split_lsu;
  import mem_lsu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  mem_dt_e     req_dt;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  errno_e      resp_err;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        mem_we;
  mem_dt_e     mem_dt;
  errno_e      mem_err;

  logic        r0_valid, r0_ready, r0_we, r0_resp_valid, r0_mem_we;
  logic [31:0] r0_addr, r0_wdata, r0_rdata, r0_mem_addr, r0_mem_wd, r0_mem_rd;
  mem_dt_e     r0_dt, r0_mem_dt;
  errno_e      r0_err, r0_mem_err;

  assign r0_mem_rd  = 32'h0;
  assign r0_mem_err = ENONE;

  mem_split_lsu #(.SPLIT_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_we(req_we), .req_dt(req_dt),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_dt(mem_dt),
    .mem_rd(mem_rd), .mem_err(mem_err)
  );

  mem_split_lsu #(.SPLIT_EN(1'b0)) u_dut_nosplit (
    .clk(clk), .rst_n(rst_n),
    .req_valid(r0_valid), .req_ready(r0_ready), .req_addr(r0_addr),
    .req_wdata(r0_wdata), .req_we(r0_we), .req_dt(r0_dt),
    .resp_valid(r0_resp_valid), .resp_rdata(r0_rdata), .resp_err(r0_err),
    .mem_addr(r0_mem_addr), .mem_wd(r0_mem_wd), .mem_we(r0_mem_we), .mem_dt(r0_mem_dt),
    .mem_rd(r0_mem_rd), .mem_err(r0_mem_err)
  );

  // Byte-addressed data memory: 256 bytes mapped, everything else faults.
  logic [7:0]  mem_b [256];
  logic [7:0]  exp_b [256];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_data;
  logic [7:0]  m_idx;
  logic [31:0] m_w;

  always_comb begin
    m_idx   = mem_addr[7:0];
    m_w     = {mem_b[m_idx + 8'd3], mem_b[m_idx + 8'd2], mem_b[m_idx + 8'd1], mem_b[m_idx]};
    mem_err = (mem_addr < 32'd256) ? ENONE : EFAULT;
    case (mem_dt)
      MEM_DT_BYTE:  mem_rd = {{24{m_w[7]}}, m_w[7:0]};
      MEM_DT_UBYTE: mem_rd = {24'h0, m_w[7:0]};
      MEM_DT_HALF:  mem_rd = {{16{m_w[15]}}, m_w[15:0]};
      MEM_DT_UHALF: mem_rd = {16'h0, m_w[15:0]};
      default:      mem_rd = m_w;
    endcase
  end

  always @(posedge clk) begin
    if (pl_en) begin
      mem_b[{pl_idx, 2'd0}] <= pl_data[7:0];
      mem_b[{pl_idx, 2'd1}] <= pl_data[15:8];
      mem_b[{pl_idx, 2'd2}] <= pl_data[23:16];
      mem_b[{pl_idx, 2'd3}] <= pl_data[31:24];
    end else if (mem_we && mem_addr < 32'd256) begin
      mem_b[m_idx] <= mem_wd[7:0];
      if (mem_dt == MEM_DT_HALF || mem_dt == MEM_DT_UHALF || mem_dt == MEM_DT_WORD)
        mem_b[m_idx + 8'd1] <= mem_wd[15:8];
      if (mem_dt == MEM_DT_WORD) begin
        mem_b[m_idx + 8'd2] <= mem_wd[23:16];
        mem_b[m_idx + 8'd3] <= mem_wd[31:24];
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic preload(input int idx, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx[5:0]; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
    for (int i = 0; i < 4; i++) exp_b[idx * 4 + i] = d[8 * i +: 8];
  endtask

  function automatic logic [31:0] word_at(input int idx);
    return {mem_b[idx * 4 + 3], mem_b[idx * 4 + 2], mem_b[idx * 4 + 1], mem_b[idx * 4]};
  endfunction

  function automatic logic [31:0] model_ext(input logic [31:0] v, input mem_dt_e dt);
    case (dt)
      MEM_DT_BYTE:  return {{24{v[7]}}, v[7:0]};
      MEM_DT_UBYTE: return {24'h0, v[7:0]};
      MEM_DT_HALF:  return {{16{v[15]}}, v[15:0]};
      MEM_DT_UHALF: return {16'h0, v[15:0]};
      default:      return v;
    endcase
  endfunction

  // Model: the request touches `size` consecutive bytes; an aligned request is one
  // beat, a misaligned one is one beat per byte and stops at the first unmapped byte.
  task automatic run_req(input logic [31:0] addr, input logic [31:0] wd, input logic we,
                         input mem_dt_e dt, input bit noisy,
                         output logic [31:0] o_rdata, output errno_e o_err);
    int          size, beats, got_cycle, diff;
    bit          aligned, busy_ok, we_ok, addr_ok;
    logic [31:0] val, a, e_rdata, e_addr;
    logic [7:0]  bi;
    errno_e      e_err;
    size    = (dt == MEM_DT_WORD) ? 4 : (dt == MEM_DT_HALF || dt == MEM_DT_UHALF) ? 2 : 1;
    aligned = ((addr % size) == 0);
    e_err   = ENONE;
    val     = 32'h0;
    if (aligned) begin
      beats = 1;
      if (addr >= 32'd256) e_err = EFAULT;
      else for (int i = 0; i < size; i++) begin
        bi = 8'(addr + 32'(i));
        if (we) exp_b[bi] = wd[8 * i +: 8];
        else    val[8 * i +: 8] = exp_b[bi];
      end
    end else begin
      beats = size;
      for (int k = 0; k < size; k++) begin
        a = addr + 32'(k);
        if (a >= 32'd256) begin
          e_err = EFAULT;
          beats = k + 1;
          break;
        end
        if (we) exp_b[a[7:0]] = wd[8 * k +: 8];
        else    val[8 * k +: 8] = exp_b[a[7:0]];
      end
    end
    e_rdata = we ? 32'h0 : model_ext(val, dt);

    o_rdata = 32'h0;
    o_err   = ENONE;
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; req_wdata = wd; req_we = we; req_dt = dt;
    @(posedge clk);
    got_cycle = 0; busy_ok = 1; we_ok = 1; addr_ok = 1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c <= beats) begin
        e_addr = aligned ? addr : addr + 32'(c - 1);
        if (mem_we !== we) we_ok = 0;
        if (mem_addr !== e_addr) addr_ok = 0;
      end else if (mem_we !== 1'b0) we_ok = 0;
      if (req_ready !== 1'b0) busy_ok = 0;
      if (resp_valid === 1'b1) begin
        got_cycle = c;
        o_rdata   = resp_rdata;
        o_err     = resp_err;
        req_valid = 1'b0;
        break;
      end
      if (noisy) begin
        req_valid = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_we    = 1'($urandom_range(0, 1));
        req_dt    = mem_dt_e'($urandom_range(0, 4));
      end else req_valid = 1'b0;
    end
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("idle_after", {30'h0, req_ready, resp_valid}, 32'h2);
    check_eq("resp_cycle", 32'(got_cycle), 32'(beats + 1));
    check_eq("resp_err", 32'(o_err), 32'(e_err));
    if (e_err == ENONE) check_eq("resp_rdata", o_rdata, e_rdata);
    check_eq("busy_ready_low", 32'(busy_ok), 32'd1);
    check_eq("mem_we_window", 32'(we_ok), 32'd1);
    check_eq("beat_addr", 32'(addr_ok), 32'd1);
    diff = 0;
    for (int i = 0; i < 256; i++) if (mem_b[i] !== exp_b[i]) diff++;
    check_eq("mem_bytes_diff", 32'(diff), 32'd0);
  endtask

  logic [31:0] rd, ra;
  errno_e      re;
  bit          noresp;

  initial begin
    rst_n = 1'b0; pl_en = 1'b0; pl_idx = '0; pl_data = '0;
    req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_we = 1'b0; req_dt = MEM_DT_WORD;
    r0_valid = 1'b0; r0_addr = '0; r0_wdata = '0; r0_we = 1'b0; r0_dt = MEM_DT_WORD;
    repeat (2) @(negedge clk);
    check_eq("rst_ready_valid_we", {29'h0, req_ready, resp_valid, mem_we}, 32'h4);
    check_eq("rst_rdata", resp_rdata, 32'h0);
    check_eq("rst_err", 32'(resp_err), 32'(ENONE));
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_mem_wd", mem_wd, 32'h0);
    check_eq("rst_mem_dt", 32'(mem_dt), 32'(MEM_DT_WORD));
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) preload(i, $urandom);

    // Aligned half store
    preload(12, 32'h12345678);
    run_req(32'd48, 32'h0000dead, 1'b1, MEM_DT_HALF, 1'b0, rd, re);
    check_eq("t1_word12", word_at(12), 32'h1234dead);

    // Misaligned half store across a word boundary
    preload(12, 32'h12345678); preload(13, 32'h0);
    run_req(32'd51, 32'h0000dead, 1'b1, MEM_DT_HALF, 1'b0, rd, re);
    check_eq("t2_word12", word_at(12), 32'had345678);
    check_eq("t2_word13", word_at(13), 32'h000000de);

    // Misaligned loads with sign and zero extension
    preload(12, 32'h82848688); preload(13, 32'h112233f4);
    run_req(32'd51, 32'h0, 1'b0, MEM_DT_HALF, 1'b0, rd, re);
    check_eq("t3_half", rd, 32'hfffff482);
    run_req(32'd51, 32'h0, 1'b0, MEM_DT_UHALF, 1'b0, rd, re);
    check_eq("t3_uhalf", rd, 32'h0000f482);

    // Four-beat word load with request noise while busy
    run_req(32'd49, 32'h0, 1'b0, MEM_DT_WORD, 1'b1, rd, re);
    check_eq("t4_word", rd, 32'hf4828486);

    // Store beats already written stay written when a later beat faults
    run_req(32'd255, 32'h0000a55a, 1'b1, MEM_DT_HALF, 1'b0, rd, re);
    check_eq("partial_store_byte", {24'h0, mem_b[255]}, 32'h5a);

    // Reset during beat 2 of a misaligned load
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'd51; req_we = 1'b0; req_dt = MEM_DT_HALF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_ready_valid_we", {29'h0, req_ready, resp_valid, mem_we}, 32'h4);
    check_eq("midrst_mem_addr", mem_addr, 32'h0);
    noresp = 1;
    repeat (2) begin @(negedge clk); if (resp_valid !== 1'b0) noresp = 0; end
    rst_n = 1'b1;
    repeat (4) begin @(negedge clk); if (resp_valid !== 1'b0) noresp = 0; end
    check_eq("midrst_no_resp", 32'(noresp), 32'd1);
    preload(12, 32'h12345678);
    run_req(32'd48, 32'h0000dead, 1'b1, MEM_DT_HALF, 1'b0, rd, re);
    check_eq("post_rst_word12", word_at(12), 32'h1234dead);

    // Randomized requests
    for (int t = 0; t < 60; t++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 7)      ra = $urandom_range(0, 255);
      else if (sel < 9) ra = $urandom_range(248, 263);
      else              ra = 32'hffff_fffc + $urandom_range(0, 3);
      run_req(ra, $urandom, 1'($urandom_range(0, 1)), mem_dt_e'($urandom_range(0, 4)),
              1'($urandom_range(0, 1)), rd, re);
    end

    // Non-splitting instance: misaligned store is rejected without touching mem
    @(negedge clk);
    r0_valid = 1'b1; r0_addr = 32'd50; r0_we = 1'b1; r0_dt = MEM_DT_WORD; r0_wdata = $urandom;
    @(posedge clk);
    @(negedge clk);
    r0_valid = 1'b0;
    check_eq("ns_resp_cycle1", {31'h0, r0_resp_valid}, 32'h1);
    check_eq("ns_err", 32'(r0_err), 32'(EALIGN));
    check_eq("ns_mem_we", {31'h0, r0_mem_we}, 32'h0);
    @(negedge clk);
    check_eq("ns_idle_after", {29'h0, r0_ready, r0_resp_valid, r0_mem_we}, 32'h4);
    @(negedge clk);
    r0_valid = 1'b1; r0_addr = 32'd48; r0_we = 1'b0; r0_dt = MEM_DT_WORD;
    @(posedge clk);
    @(negedge clk);
    r0_valid = 1'b0;
    check_eq("ns_aligned_beat", {r0_mem_addr[29:0], r0_resp_valid, r0_mem_we}, {30'd48, 2'b00});
    @(negedge clk);
    check_eq("ns_aligned_resp", {31'h0, r0_resp_valid}, 32'h1);
    check_eq("ns_aligned_err", 32'(r0_err), 32'(ENONE));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
